// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NREQ requesters.
// It runs one IDLE -> EXEC -> RESP round per granted request and returns the id-tagged result.
module alu_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [DW-1:0]     rsp_data,
    output logic              alu_e1,
    output logic              alu_e2_b,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DW-1:0]     alu_y
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic           alu_e1_q, alu_e1_d;
    logic           alu_e2_b_q, alu_e2_b_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [2:0]     alu_sel_q, alu_sel_d;

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] idx;

    // Search starts just after the last winner and wraps, so every valid requester is reached.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_q) + k) % NREQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Grant is only offered in IDLE; gated by rst_n so it reads zero while reset is held.
    assign req_ready = (rst_n && state_q == IDLE && win_found) ?
                       (NREQ'(1) << win_idx) : '0;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        alu_e1_d    = alu_e1_q;
        alu_e2_b_d  = alu_e2_b_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    alu_a_d    = req_a[int'(win_idx)*DW +: DW];
                    alu_b_d    = req_b[int'(win_idx)*DW +: DW];
                    alu_sel_d  = req_op[int'(win_idx)*3 +: 3];
                    id_d       = win_idx;
                    last_d     = win_idx;
                    alu_e1_d   = 1'b1;
                    alu_e2_b_d = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // Operands stay on the ALU pins; only the enables drop.
                rsp_data_d  = alu_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                alu_e1_d    = 1'b0;
                alu_e2_b_d  = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            alu_e1_q    <= 1'b0;
            alu_e2_b_q  <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            alu_e1_q    <= alu_e1_d;
            alu_e2_b_q  <= alu_e2_b_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign alu_e1    = alu_e1_q;
    assign alu_e2_b  = alu_e2_b_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small behavioural 4-bit ALU attached.
module tb_alu_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a, req_b;
    logic [11:0] req_op;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        alu_e1, alu_e2_b;
    logic [3:0]  alu_a, alu_b, alu_y;
    logic [2:0]  alu_sel;

    logic [3:0]  a [4];
    logic [3:0]  b [4];
    logic [2:0]  op [4];

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;
    int prev_cyc;

    assign req_a  = {a[3], a[2], a[1], a[0]};
    assign req_b  = {b[3], b[2], b[1], b[0]};
    assign req_op = {op[3], op[2], op[1], op[0]};

    alu_rr_arbiter #(.NREQ(4), .DW(4), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_e1(alu_e1), .alu_e2_b(alu_e2_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y)
    );

    always_comb begin
        case (alu_sel)
            3'd0:    alu_y = alu_a + alu_b;
            3'd1:    alu_y = alu_a - alu_b;
            3'd2:    alu_y = alu_a & alu_b;
            3'd3:    alu_y = alu_a - 4'd1;
            3'd4:    alu_y = alu_a + 4'd1;
            3'd5:    alu_y = alu_a << 1;
            3'd6:    alu_y = ~alu_b;
            default: alu_y = alu_b + 4'd2;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] sweep_exp [8];

    initial begin
        sweep_exp = '{4'd15, 4'd5, 4'd0, 4'd9, 4'd11, 4'd4, 4'd10, 4'd7};
        for (int i = 0; i < 4; i++) begin
            a[i] = '0; b[i] = '0; op[i] = '0;
        end
        rst_n = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_e1", alu_e1, 0);
        chk("rst_e2_b", alu_e2_b, 1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_sel", alu_sel, 0);
        req_valid = 4'b0000;
        do_reset();

        // 1: single request
        a[0] = 4'd10; b[0] = 4'd5; op[0] = 3'd0;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("t1_grant", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        chk("t1_exec_ready", req_ready, 0);
        chk("t1_exec_e1", alu_e1, 1);
        chk("t1_exec_e2_b", alu_e2_b, 0);
        chk("t1_alu_a", alu_a, 10);
        chk("t1_alu_b", alu_b, 5);
        chk("t1_exec_rsp_valid", rsp_valid, 0);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_data", rsp_data, 15);
        chk("t1_resp_e1", alu_e1, 0);
        chk("t1_resp_e2_b", alu_e2_b, 1);
        tick();
        chk("t1_rsp_done", rsp_valid, 0);

        // 2: all four held valid, rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = 4'(i); b[i] = 4'd1; op[i] = 3'd1;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        prev_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            chk("t2_grant", req_ready, 4'b0001 << (n % 4));
            if (n > 0) chk("t2_spacing", cyc - prev_cyc, 3);
            prev_cyc = cyc;
            tick();
            tick();
            chk("t2_rsp_valid", rsp_valid, 1);
            chk("t2_rsp_id", rsp_id, n % 4);
            chk("t2_rsp_data", rsp_data, ((n % 4) + 15) % 16);
            if (n == 4) req_valid = 4'b0000;
            tick();
        end

        // 3: backpressure on the response channel
        a[1] = 4'd3; b[1] = 4'd4; op[1] = 3'd0;
        a[2] = 4'd2; b[2] = 4'd1; op[2] = 3'd1;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        chk("t3_grant1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0100;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_data", rsp_data, 7);
            chk("t3_hold_id", rsp_id, 1);
            chk("t3_hold_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_resp_ready", req_ready, 0);
        tick();
        chk("t3_grant2", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t3_rsp2_id", rsp_id, 2);
        chk("t3_rsp2_data", rsp_data, 1);
        tick();

        // 4: withdrawn request from requester 2
        a[0] = 4'd10; b[0] = 4'd5; op[0] = 3'd0;
        a[3] = 4'd3;  b[3] = 4'd1; op[3] = 3'd1;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        chk("t4_grant0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t4_rsp0_id", rsp_id, 0);
        chk("t4_rsp0_data", rsp_data, 15);
        req_valid = 4'b0100;
        #1;
        chk("t4_pulse_ready", req_ready, 0);
        tick();
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        tick();
        chk("t4_grant3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t4_rsp3_valid", rsp_valid, 1);
        chk("t4_rsp3_id", rsp_id, 3);
        chk("t4_rsp3_data", rsp_data, 2);
        tick();
        chk("t4_idle_ready", req_ready, 0);
        chk("t4_idle_valid", rsp_valid, 0);

        // 5: reset while a response is pending
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        chk("t5_grant1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t5_pre_valid", rsp_valid, 1);
        chk("t5_pre_id", rsp_id, 1);
        #1 rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("t5_rst_valid", rsp_valid, 0);
        chk("t5_rst_id", rsp_id, 0);
        chk("t5_rst_data", rsp_data, 0);
        chk("t5_rst_e1", alu_e1, 0);
        chk("t5_rst_e2_b", alu_e2_b, 1);
        chk("t5_rst_alu_a", alu_a, 0);
        chk("t5_rst_alu_b", alu_b, 0);
        chk("t5_rst_ready", req_ready, 0);
        do_reset();
        rsp_ready = 1'b1;
        #1;
        chk("t5_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t5_rsp_id", rsp_id, 0);
        chk("t5_rsp_data", rsp_data, 15);
        tick();

        // 6: opcode sweep on requester 1
        a[1] = 4'd10; b[1] = 4'd5;
        for (int s = 0; s < 8; s++) begin
            op[1] = 3'(s);
            req_valid = 4'b0010;
            #1;
            chk("t6_grant", req_ready, 4'b0010);
            tick();
            req_valid = 4'b0000;
            chk("t6_alu_sel", alu_sel, s);
            chk("t6_alu_e1", alu_e1, 1);
            tick();
            chk("t6_rsp_id", rsp_id, 1);
            chk("t6_rsp_data", rsp_data, sweep_exp[s]);
            chk("t6_sel_hold", alu_sel, s);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
